// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the frame-aware FIFO family.
//   log2      : address bits needed for n entries (never less than 1)
//   log2_cnt  : bits needed to hold a count from 0 to n inclusive
//   wrap_inc  : pointer increment that wraps from depth-1 back to 0,
//               so non-power-of-two depths work without extra masking
package sync_fifo_pkg;

  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int log2_cnt(input int n);
    return log2(n + 1);
  endfunction

  function automatic int wrap_inc(input int p, input int depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM with a registered, enabled read port.
//   clk, rst          : clock; rst clears only the read data register
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr     : read port; rd_data updates the cycle after rd_en
//                       and holds otherwise (read-first on address clash)
//   RAM_STYLE         : 1 = block RAM, 0 = distributed RAM
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 65,
  parameter int RAM_STYLE = 1,
  parameter int ABITS     = log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [ABITS-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  if (RAM_STYLE != 0) begin : g_block
    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
    end
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_pkt_fifo.sv
// Frame-aware single-clock FIFO. Words are written tentatively and become
// visible to the reader only once the frame's eop word is accepted. A frame
// is discarded on explicit abort, on overflow, or when the committed-frame
// limit is reached; its words are reclaimed by rolling wr_ptr back.
//
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_wr_en, i_din         : write strobe and data
//   i_wr_eop               : this write is the last word of the frame
//   i_wr_abort             : discard the frame being written
//   o_full, o_almost_full  : occupancy incl. uncommitted words
//   o_drop                 : one-cycle pulse when a frame is discarded
//   i_rd_en                : read strobe
//   o_dout, o_rd_eop       : read data and its eop flag
//   o_empty, o_data_cnt    : committed, unread words
//   o_frame_cnt            : committed, not fully read frames
//
// Handshake: a strobe is an offer, the status flag is the ready. A write is
// taken when i_wr_en is high and the FIFO is neither full nor overflowing
// nor aborting; a read is taken when i_rd_en is high and o_empty is low.
// Strobes that are not taken leave pointers and counters untouched.
module sync_pkt_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH                 = 512,
  parameter int WIDTH                 = 64,
  parameter int FRAME_MAX             = 64,
  parameter int ALMOST_FULL_THRESHOLD = 16,
  parameter int FWFT                  = 0,
  parameter int RAM_STYLE             = 1,
  parameter int BADDR                 = log2(DEPTH),
  parameter int CNT_WIDTH             = log2_cnt(DEPTH)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [WIDTH-1:0]               i_din,
  input  logic                           i_wr_eop,
  input  logic                           i_wr_abort,
  output logic                           o_full,
  output logic                           o_almost_full,
  output logic                           o_drop,
  input  logic                           i_rd_en,
  output logic [WIDTH-1:0]               o_dout,
  output logic                           o_rd_eop,
  output logic                           o_empty,
  output logic [CNT_WIDTH-1:0]           o_data_cnt,
  output logic [log2_cnt(FRAME_MAX)-1:0] o_frame_cnt
);

  localparam int FCW = log2_cnt(FRAME_MAX);

  logic [BADDR-1:0]     wr_ptr, wr_cmt_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic [CNT_WIDTH-1:0] used, cmt, used_n, cmt_n;
  logic [FCW-1:0]       frame_cnt;
  logic                 ovf, drop;
  // Shadow of the stored eop bits so the frame count can drop in the same
  // cycle as the read, independent of the RAM's read latency.
  logic [DEPTH-1:0]     eop_map;

  logic in_frame, frames_full, wr_store, commit, discard, ovf_set;
  logic rd_accept, rd_is_eop;

  logic             ram_rd_en;
  logic [BADDR-1:0] ram_rd_addr;
  logic [WIDTH:0]   ram_q;

  assign o_full        = (used == CNT_WIDTH'(DEPTH));
  assign o_empty       = (cmt == '0);
  assign o_data_cnt    = cmt;
  assign o_frame_cnt   = frame_cnt;
  assign o_drop        = drop;
  assign o_almost_full = (32'(DEPTH) - 32'(used)) <= 32'(ALMOST_FULL_THRESHOLD);

  always_comb begin
    wr_ptr_inc  = BADDR'(wrap_inc(32'(wr_ptr), DEPTH));
    rd_ptr_inc  = BADDR'(wrap_inc(32'(rd_ptr), DEPTH));
    // used != cmt is unambiguous even when the whole RAM is tentative,
    // where the two write pointers would compare equal.
    in_frame    = (used != cmt) || ovf;
    frames_full = (frame_cnt == FCW'(FRAME_MAX));
    rd_accept   = i_rd_en && !o_empty;
    rd_is_eop   = eop_map[rd_ptr];
    wr_store    = i_wr_en && !i_wr_abort && !o_full && !ovf && !(i_wr_eop && frames_full);
    commit      = wr_store && i_wr_eop;
    // An eop that lands on a full FIFO is itself an overflow: the frame is
    // dropped immediately rather than poisoning the next frame.
    discard     = (i_wr_abort && in_frame) ||
                  (i_wr_en && i_wr_eop && !i_wr_abort && (ovf || o_full || frames_full));
    ovf_set     = i_wr_en && !i_wr_eop && !i_wr_abort && o_full;

    used_n = used + CNT_WIDTH'(wr_store) - CNT_WIDTH'(rd_accept);
    if (discard) used_n = cmt - CNT_WIDTH'(rd_accept);
    // A commit makes every tentative word visible, so cmt catches up with used.
    cmt_n = commit ? used_n : (cmt - CNT_WIDTH'(rd_accept));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      wr_cmt_ptr <= '0;
      rd_ptr     <= '0;
      used       <= '0;
      cmt        <= '0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
      drop       <= 1'b0;
    end else begin
      used      <= used_n;
      cmt       <= cmt_n;
      drop      <= discard;
      frame_cnt <= frame_cnt + FCW'(commit) - FCW'(rd_accept && rd_is_eop);
      if (rd_accept) rd_ptr <= rd_ptr_inc;
      if (discard) begin
        wr_ptr <= wr_cmt_ptr;
        ovf    <= 1'b0;
      end else begin
        if (wr_store) wr_ptr     <= wr_ptr_inc;
        if (commit)   wr_cmt_ptr <= wr_ptr_inc;
        if (ovf_set)  ovf        <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_store) eop_map[wr_ptr] <= i_wr_eop;
  end

  sync_fifo_ram #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH + 1),
    .RAM_STYLE(RAM_STYLE),
    .ABITS    (BADDR)
  ) u_ram (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (wr_store),
    .wr_addr(wr_ptr),
    .wr_data({i_wr_eop, i_din}),
    .rd_en  (ram_rd_en),
    .rd_addr(ram_rd_addr),
    .rd_data(ram_q)
  );

  if (FWFT != 0) begin : g_fwft
    // Read-ahead: the RAM continuously fetches the slot that will be the
    // head next cycle. A word written into that slot in the same cycle is
    // not yet visible to the read-first RAM, so it is forwarded instead.
    logic           byp_hit;
    logic [WIDTH:0] byp_word;

    assign ram_rd_en   = 1'b1;
    assign ram_rd_addr = rd_accept ? rd_ptr_inc : rd_ptr;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        byp_hit  <= 1'b0;
        byp_word <= '0;
      end else begin
        byp_hit  <= wr_store && (wr_ptr == ram_rd_addr);
        byp_word <= {i_wr_eop, i_din};
      end
    end

    assign {o_rd_eop, o_dout} = byp_hit ? byp_word : ram_q;
  end else begin : g_std
    assign ram_rd_en          = rd_accept;
    assign ram_rd_addr        = rd_ptr;
    assign {o_rd_eop, o_dout} = ram_q;
  end

endmodule

// File: tb/tb_sync_pkt_fifo.sv
module tb_sync_pkt_fifo;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_eop, wr_abort, rd_en;
  logic [7:0] din;
  logic       sel6;  // 0: drive the DEPTH=8 pair, 1: drive the DEPTH=6 FIFO

  always #5 clk = ~clk;

  logic a_we, a_ab, a_re, c_we, c_ab, c_re;
  assign a_we = wr_en & ~sel6;
  assign a_ab = wr_abort & ~sel6;
  assign a_re = rd_en & ~sel6;
  assign c_we = wr_en & sel6;
  assign c_ab = wr_abort & sel6;
  assign c_re = rd_en & sel6;

  // a: DEPTH 8, standard read; b: DEPTH 8, FWFT; c: DEPTH 6, standard read
  logic       a_full, a_afull, a_drop, a_reop, a_empty;
  logic [7:0] a_dout;
  logic [3:0] a_cnt;
  logic [2:0] a_fc;
  logic       b_full, b_afull, b_drop, b_reop, b_empty;
  logic [7:0] b_dout;
  logic [3:0] b_cnt;
  logic [2:0] b_fc;
  logic       c_full, c_afull, c_drop, c_reop, c_empty;
  logic [7:0] c_dout;
  logic [2:0] c_cnt;
  logic [6:0] c_fc;

  sync_pkt_fifo #(.DEPTH(8), .WIDTH(8), .FRAME_MAX(4), .ALMOST_FULL_THRESHOLD(2),
                  .FWFT(0), .RAM_STYLE(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_wr_en(a_we), .i_din(din), .i_wr_eop(wr_eop),
    .i_wr_abort(a_ab), .o_full(a_full), .o_almost_full(a_afull), .o_drop(a_drop),
    .i_rd_en(a_re), .o_dout(a_dout), .o_rd_eop(a_reop), .o_empty(a_empty),
    .o_data_cnt(a_cnt), .o_frame_cnt(a_fc));

  sync_pkt_fifo #(.DEPTH(8), .WIDTH(8), .FRAME_MAX(4), .ALMOST_FULL_THRESHOLD(2),
                  .FWFT(1), .RAM_STYLE(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_wr_en(a_we), .i_din(din), .i_wr_eop(wr_eop),
    .i_wr_abort(a_ab), .o_full(b_full), .o_almost_full(b_afull), .o_drop(b_drop),
    .i_rd_en(a_re), .o_dout(b_dout), .o_rd_eop(b_reop), .o_empty(b_empty),
    .o_data_cnt(b_cnt), .o_frame_cnt(b_fc));

  sync_pkt_fifo #(.DEPTH(6), .WIDTH(8), .FRAME_MAX(64), .ALMOST_FULL_THRESHOLD(2),
                  .FWFT(0), .RAM_STYLE(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_wr_en(c_we), .i_din(din), .i_wr_eop(wr_eop),
    .i_wr_abort(c_ab), .o_full(c_full), .o_almost_full(c_afull), .o_drop(c_drop),
    .i_rd_en(c_re), .o_dout(c_dout), .o_rd_eop(c_reop), .o_empty(c_empty),
    .o_data_cnt(c_cnt), .o_frame_cnt(c_fc));

  // ---------------- scoreboard / reference model ----------------
  // Frames are modelled as queues of {eop, data}: cq holds committed words
  // in read order, tq holds the frame still being written.
  typedef logic [8:0] wd_t;
  wd_t cq[$];
  wd_t tq[$];
  bit  m_ovf, m_drop;
  wd_t last_rd;
  int  m_depth, m_fmax;
  int  nvec = 0;
  int  nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_frames();
    int n = 0;
    foreach (cq[i]) if (cq[i][8]) n++;
    return n;
  endfunction

  task automatic model_reset(input int depth, input int fmax);
    cq.delete();
    tq.delete();
    m_ovf   = 0;
    m_drop  = 0;
    last_rd = '0;
    m_depth = depth;
    m_fmax  = fmax;
  endtask

  task automatic model_step(input bit we, input logic [7:0] d, input bit eop,
                            input bit ab, input bit re);
    bit full, empty, inprog;
    int frames;
    full   = (cq.size() + tq.size()) == m_depth;
    empty  = cq.size() == 0;
    inprog = (tq.size() != 0) || m_ovf;
    frames = m_frames();
    m_drop = 0;
    if (re && !empty) last_rd = cq.pop_front();
    if (ab) begin
      if (inprog) begin
        tq.delete();
        m_ovf  = 0;
        m_drop = 1;
      end
    end else if (we) begin
      if (eop) begin
        if (m_ovf || full || frames >= m_fmax) begin
          tq.delete();
          m_ovf  = 0;
          m_drop = 1;
        end else begin
          tq.push_back({1'b1, d});
          foreach (tq[i]) cq.push_back(tq[i]);
          tq.delete();
        end
      end else if (full || m_ovf) begin
        m_ovf = 1;
      end else begin
        tq.push_back({1'b0, d});
      end
    end
  endtask

  task automatic check_all();
    int used;
    bit e_empty, e_full, e_af;
    used    = cq.size() + tq.size();
    e_empty = cq.size() == 0;
    e_full  = used == m_depth;
    e_af    = (m_depth - used) <= 2;
    if (!sel6) begin
      chk("a_empty", 32'(a_empty), 32'(e_empty));
      chk("a_full", 32'(a_full), 32'(e_full));
      chk("a_afull", 32'(a_afull), 32'(e_af));
      chk("a_drop", 32'(a_drop), 32'(m_drop));
      chk("a_data_cnt", 32'(a_cnt), cq.size());
      chk("a_frame_cnt", 32'(a_fc), m_frames());
      chk("a_dout", 32'({a_reop, a_dout}), 32'(last_rd));
      chk("b_empty", 32'(b_empty), 32'(e_empty));
      chk("b_full", 32'(b_full), 32'(e_full));
      chk("b_afull", 32'(b_afull), 32'(e_af));
      chk("b_drop", 32'(b_drop), 32'(m_drop));
      chk("b_data_cnt", 32'(b_cnt), cq.size());
      chk("b_frame_cnt", 32'(b_fc), m_frames());
      if (!e_empty) chk("b_head", 32'({b_reop, b_dout}), 32'(cq[0]));
    end else begin
      chk("c_empty", 32'(c_empty), 32'(e_empty));
      chk("c_full", 32'(c_full), 32'(e_full));
      chk("c_afull", 32'(c_afull), 32'(e_af));
      chk("c_drop", 32'(c_drop), 32'(m_drop));
      chk("c_data_cnt", 32'(c_cnt), cq.size());
      chk("c_frame_cnt", 32'(c_fc), m_frames());
      chk("c_dout", 32'({c_reop, c_dout}), 32'(last_rd));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input bit we, input logic [7:0] d, input bit eop,
                      input bit ab, input bit re);
    wr_en    = we;
    din      = d;
    wr_eop   = eop;
    wr_abort = ab;
    rd_en    = re;
    @(posedge clk);
    model_step(we, d, eop, ab, re);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int depth, input int fmax);
    rst      = 1'b1;
    wr_en    = 1'b0;
    din      = '0;
    wr_eop   = 1'b0;
    wr_abort = 1'b0;
    rd_en    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset(depth, fmax);
    check_all();
    if (!sel6) chk("b_dout_rst", 32'({b_reop, b_dout}), 32'(0));
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0, 1);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      tick($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         we;
    logic [7:0] d;
    bit         eop;
    bit         ab;
    bit         re;
    bit         e_empty;
    bit         e_drop;
    int         e_cnt;
    int         e_fc;
    logic [8:0] e_word;   // {o_rd_eop, o_dout} of the standard-read FIFO
    logic [8:0] e_head;   // FWFT head word, checked when not empty
  } vec_t;

  vec_t tbl[13];

  initial begin
    // 3-word frame, read back, then 2-word frame aborted, then 1-word frame
    tbl[0]  = '{1, 8'h0A, 0, 0, 0, 1, 0, 0, 0, 9'h000, 9'h000};
    tbl[1]  = '{1, 8'h0B, 0, 0, 0, 1, 0, 0, 0, 9'h000, 9'h000};
    tbl[2]  = '{1, 8'h0C, 1, 0, 0, 0, 0, 3, 1, 9'h000, 9'h00A};
    tbl[3]  = '{0, 8'h00, 0, 0, 1, 0, 0, 2, 1, 9'h00A, 9'h00B};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 0, 0, 1, 1, 9'h00B, 9'h10C};
    tbl[5]  = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 9'h10C, 9'h000};
    tbl[6]  = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 9'h10C, 9'h000};
    tbl[7]  = '{1, 8'h01, 0, 0, 0, 1, 0, 0, 0, 9'h10C, 9'h000};
    tbl[8]  = '{1, 8'h02, 0, 0, 0, 1, 0, 0, 0, 9'h10C, 9'h000};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 1, 1, 0, 0, 9'h10C, 9'h000};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 9'h10C, 9'h000};
    tbl[11] = '{1, 8'h05, 1, 0, 0, 0, 0, 1, 1, 9'h10C, 9'h105};
    tbl[12] = '{0, 8'h00, 0, 0, 1, 1, 0, 0, 0, 9'h105, 9'h000};

    sel6 = 1'b0;
    do_reset(8, 4);

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].we, tbl[i].d, tbl[i].eop, tbl[i].ab, tbl[i].re);
      chk("tbl_empty", 32'(a_empty), 32'(tbl[i].e_empty));
      chk("tbl_drop", 32'(a_drop), 32'(tbl[i].e_drop));
      chk("tbl_data_cnt", 32'(a_cnt), tbl[i].e_cnt);
      chk("tbl_frame_cnt", 32'(a_fc), tbl[i].e_fc);
      chk("tbl_word", 32'({a_reop, a_dout}), 32'(tbl[i].e_word));
      chk("tbl_full", 32'(a_full), 32'(0));
      if (!tbl[i].e_empty) chk("tbl_fwft_head", 32'({b_reop, b_dout}), 32'(tbl[i].e_head));
    end

    // Overflow: 5 committed words, then a 6-word frame that cannot fit
    for (int i = 0; i < 5; i++) tick(1, 8'(8'h10 + i), i == 4, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1, 8'(8'h20 + i), i == 5, 0, 0);
      if (i == 2) chk("ovf_full", 32'(a_full), 32'(1));
    end
    chk("ovf_drop", 32'(a_drop), 32'(1));
    chk("ovf_data_cnt", 32'(a_cnt), 32'(5));
    chk("ovf_full_after", 32'(a_full), 32'(0));
    drain(5);
    chk("ovf_last", 32'({a_reop, a_dout}), 32'(9'h114));

    // Read last word of frame 1 in the same cycle frame 2 commits
    tick(1, 8'h31, 0, 0, 0);
    tick(1, 8'h32, 1, 0, 0);
    tick(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 8'(8'h40 + i), 0, 0, 0);
    tick(1, 8'h43, 1, 0, 1);
    chk("rc_data_cnt", 32'(a_cnt), 32'(4));
    chk("rc_frame_cnt", 32'(a_fc), 32'(1));
    chk("rc_read_word", 32'({a_reop, a_dout}), 32'(9'h132));
    drain(4);

    // Committed-frame limit: the fifth frame is dropped
    for (int i = 0; i < 4; i++) tick(1, 8'(8'h50 + i), 1, 0, 0);
    tick(1, 8'h55, 1, 0, 0);
    chk("fmax_drop", 32'(a_drop), 32'(1));
    chk("fmax_frame_cnt", 32'(a_fc), 32'(4));
    tick(0, 8'h00, 0, 1, 0);
    chk("idle_abort_nodrop", 32'(a_drop), 32'(0));
    drain(4);

    // Abort wins over a same-cycle eop
    tick(1, 8'h60, 0, 0, 0);
    tick(1, 8'h61, 1, 1, 0);
    chk("abort_eop_drop", 32'(a_drop), 32'(1));
    chk("abort_eop_empty", 32'(a_empty), 32'(1));

    random_run(400);

    // Reset in the middle of a frame: contents gone, no drop pulse
    tick(1, 8'h70, 0, 0, 0);
    tick(1, 8'h71, 0, 0, 0);
    do_reset(8, 4);

    // Non-power-of-two depth: streamed one-word frames with concurrent reads
    sel6 = 1'b1;
    do_reset(6, 64);
    for (int i = 0; i < 20; i++) begin
      tick(1, 8'(8'h80 + i), 1, 0, i > 0);
      chk("c_fc_bound", 32'(c_fc <= 7'd6), 32'(1));
    end
    drain(2);
    chk("c_stream_last", 32'({c_reop, c_dout}), 32'(9'h193));
    random_run(400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
